// File: rtl/dmem_waitstate.sv
// dmem_waitstate: wait-stated byte-addressable data memory with ready/valid request and one-cycle response
module dmem_waitstate #(
  parameter int XLEN = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            req_ready,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_err,
  output logic            busy
);
  localparam int AW = $clog2(DEPTH_WORDS);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;
  state_t state, state_nx, first;
  logic [3:0] cnt;
  logic we_q;
  logic [2:0] f3_q;
  logic [AW+1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] mem [DEPTH_WORDS];
  logic [XLEN-1:0] word, merged, load_data, wd_rep;
  logic [3:0] be;
  logic [7:0] lane_b;
  logic [15:0] lane_h;
  logic accept, err, unused_addr;
  assign req_ready = state == S_IDLE || state == S_RESP;
  assign busy = state == S_WAIT || state == S_ACCESS;
  assign accept = req_valid && req_ready;
  assign first = WAIT_CYCLES > 0 ? S_WAIT : S_ACCESS;
  assign unused_addr = ^req_addr[XLEN-1:AW+2];
  assign word = mem[addr_q[AW+1:2]];
  assign err = f3_q == 3'b011 || f3_q[2:1] == 2'b11 || (we_q && f3_q[2]) ||
               (f3_q[1:0] == 2'b01 && addr_q[0]) || (f3_q[1:0] == 2'b10 && addr_q[1:0] != 2'b00);
  assign lane_b = word[8*addr_q[1:0] +: 8];
  assign lane_h = addr_q[1] ? word[31:16] : word[15:0];
  assign load_data = f3_q == 3'b000 ? {{24{lane_b[7]}}, lane_b} :
                     f3_q == 3'b100 ? {24'b0, lane_b} :
                     f3_q == 3'b001 ? {{16{lane_h[15]}}, lane_h} :
                     f3_q == 3'b101 ? {16'b0, lane_h} : word;
  assign be = f3_q[1:0] == 2'b00 ? 4'b0001 << addr_q[1:0] :
              f3_q[1:0] == 2'b01 ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign wd_rep = f3_q[1:0] == 2'b00 ? {4{wdata_q[7:0]}} :
                  f3_q[1:0] == 2'b01 ? {2{wdata_q[15:0]}} : wdata_q;
  for (genvar g = 0; g < 4; g++) begin : g_lane
    assign merged[8*g +: 8] = be[g] ? wd_rep[8*g +: 8] : word[8*g +: 8];
  end
  always_comb begin
    state_nx = state == S_IDLE || state == S_RESP ? (accept ? first : S_IDLE) :
               state == S_WAIT ? (cnt == 4'd1 ? S_ACCESS : S_WAIT) : S_RESP;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      cnt <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= accept ? 4'(WAIT_CYCLES) : state == S_WAIT ? cnt - 4'd1 : cnt;
      rsp_valid <= state == S_ACCESS;
      rsp_rdata <= state == S_ACCESS && !we_q && !err ? load_data : '0;
      rsp_err <= state == S_ACCESS && err;
    end
  end
  always_ff @(posedge clk) begin
    if (accept) begin
      we_q <= req_we;
      f3_q <= req_funct3;
      addr_q <= req_addr[AW+1:0];
      wdata_q <= req_wdata;
    end
    if (state == S_ACCESS && we_q && !err) mem[addr_q[AW+1:2]] <= merged;
  end
endmodule

// File: tb/tb_dmem_waitstate.sv
// tb_dmem_waitstate: directed table-driven check of dmem_waitstate with 2 and 0 wait states
module tb_dmem_waitstate;
  typedef struct {
    logic we;
    logic [2:0] f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd;
    logic err;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic req_valid = 1'b0;
  logic req_we = 1'b0;
  logic [2:0] req_funct3 = 3'b010;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic a_rdy, a_vld, a_err, a_busy, b_rdy, b_vld, b_err, b_busy;
  logic [31:0] a_rd, b_rd;
  int checks = 0;
  int failures = 0;
  vec_t tv[$];
  dmem_waitstate #(.XLEN(32), .DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut_a (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(a_rdy), .rsp_valid(a_vld),
    .rsp_rdata(a_rd), .rsp_err(a_err), .busy(a_busy)
  );
  dmem_waitstate #(.XLEN(32), .DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut_b (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(b_rdy), .rsp_valid(b_vld),
    .rsp_rdata(b_rd), .rsp_err(b_err), .busy(b_busy)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic do_req(input vec_t v, input int idx);
    int a_k, b_k, a_n, b_n;
    logic [31:0] a_d, b_d;
    logic a_e, b_e, busy_ok;
    a_k = 0; b_k = 0; a_n = 0; b_n = 0; a_d = 'x; b_d = 'x; a_e = 1'bx; b_e = 1'bx; busy_ok = 1'b1;
    @(negedge clk);
    req_we = v.we; req_funct3 = v.f3; req_addr = v.addr; req_wdata = v.wdata; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (a_vld) begin
        a_n++;
        if (a_k == 0) begin a_k = k; a_d = a_rd; a_e = a_err; end
      end
      if (b_vld) begin
        b_n++;
        if (b_k == 0) begin b_k = k; b_d = b_rd; b_e = b_err; end
      end
      if (k <= 3 && (!a_busy || a_rdy)) busy_ok = 1'b0;
    end
    check($sformatf("v%0d a_latency", idx), a_k, 4);
    check($sformatf("v%0d a_pulses", idx), a_n, 1);
    check($sformatf("v%0d a_rdata", idx), a_d, v.rd);
    check($sformatf("v%0d a_err", idx), {31'b0, a_e}, {31'b0, v.err});
    check($sformatf("v%0d a_busy", idx), {31'b0, busy_ok}, 1);
    check($sformatf("v%0d b_latency", idx), b_k, 2);
    check($sformatf("v%0d b_pulses", idx), b_n, 1);
    check($sformatf("v%0d b_rdata", idx), b_d, v.rd);
    check($sformatf("v%0d b_err", idx), {31'b0, b_e}, {31'b0, v.err});
  endtask
  initial begin
    vec_t v;
    logic [31:0] b2b_rd [4];
    logic [2:0] b2b_f3 [4];
    logic [31:0] b2b_addr [4];
    int stray;
    tv.push_back('{1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0});
    tv.push_back('{1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0});
    tv.push_back('{1'b1, 3'b010, 32'h10, 32'h11223344, 32'h0, 1'b0});
    tv.push_back('{1'b1, 3'b000, 32'h13, 32'h000000A5, 32'h0, 1'b0});
    tv.push_back('{1'b0, 3'b010, 32'h10, 32'h0, 32'hA5223344, 1'b0});
    tv.push_back('{1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFFA5, 1'b0});
    tv.push_back('{1'b0, 3'b100, 32'h13, 32'h0, 32'h000000A5, 1'b0});
    tv.push_back('{1'b0, 3'b100, 32'h10, 32'h0, 32'h00000044, 1'b0});
    tv.push_back('{1'b0, 3'b000, 32'h12, 32'h0, 32'h00000022, 1'b0});
    tv.push_back('{1'b1, 3'b010, 32'h20, 32'h80017FFF, 32'h0, 1'b0});
    tv.push_back('{1'b0, 3'b001, 32'h22, 32'h0, 32'hFFFF8001, 1'b0});
    tv.push_back('{1'b0, 3'b101, 32'h22, 32'h0, 32'h00008001, 1'b0});
    tv.push_back('{1'b0, 3'b001, 32'h20, 32'h0, 32'h00007FFF, 1'b0});
    tv.push_back('{1'b0, 3'b000, 32'h21, 32'h0, 32'h0000007F, 1'b0});
    tv.push_back('{1'b0, 3'b100, 32'h22, 32'h0, 32'h00000001, 1'b0});
    tv.push_back('{1'b0, 3'b010, 32'h21, 32'h0, 32'h0, 1'b1});
    tv.push_back('{1'b0, 3'b010, 32'h22, 32'h0, 32'h0, 1'b1});
    tv.push_back('{1'b0, 3'b001, 32'h21, 32'h0, 32'h0, 1'b1});
    tv.push_back('{1'b1, 3'b001, 32'h23, 32'h0000FFFF, 32'h0, 1'b1});
    tv.push_back('{1'b1, 3'b100, 32'h20, 32'h0000FFFF, 32'h0, 1'b1});
    tv.push_back('{1'b0, 3'b011, 32'h20, 32'h0, 32'h0, 1'b1});
    tv.push_back('{1'b0, 3'b111, 32'h20, 32'h0, 32'h0, 1'b1});
    tv.push_back('{1'b0, 3'b010, 32'h20, 32'h0, 32'h80017FFF, 1'b0});
    tv.push_back('{1'b1, 3'b001, 32'h22, 32'h0000BEEF, 32'h0, 1'b0});
    tv.push_back('{1'b0, 3'b010, 32'h20, 32'h0, 32'hBEEF7FFF, 1'b0});
    tv.push_back('{1'b0, 3'b001, 32'h22, 32'h0, 32'hFFFFBEEF, 1'b0});
    tv.push_back('{1'b1, 3'b010, 32'h440, 32'hCAFEF00D, 32'h0, 1'b0});
    tv.push_back('{1'b0, 3'b010, 32'h40, 32'h0, 32'hCAFEF00D, 1'b0});
    tv.push_back('{1'b1, 3'b010, 32'h40, 32'h0, 32'h0, 1'b0});
    tv.push_back('{1'b0, 3'b010, 32'h440, 32'h0, 32'h0, 1'b0});
    b2b_f3 = '{3'b010, 3'b000, 3'b101, 3'b010};
    b2b_addr = '{32'h10, 32'h13, 32'h22, 32'h20};
    b2b_rd = '{32'hA5223344, 32'hFFFFFFA5, 32'h0000BEEF, 32'hBEEF7FFF};
    repeat (2) @(negedge clk);
    check("reset a_ready", {31'b0, a_rdy}, 1);
    check("reset a_busy", {31'b0, a_busy}, 0);
    check("reset a_rsp_valid", {31'b0, a_vld}, 0);
    check("reset a_rdata", a_rd, 0);
    check("reset a_err", {31'b0, a_err}, 0);
    check("reset b_ready", {31'b0, b_rdy}, 1);
    reset = 1'b0;
    for (int i = 0; i < tv.size(); i++) do_req(tv[i], i);
    @(negedge clk);
    req_we = 1'b0; req_funct3 = b2b_f3[0]; req_addr = b2b_addr[0]; req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("b2b%0d access_busy", i), {31'b0, b_busy}, 1);
      check($sformatf("b2b%0d access_ready", i), {31'b0, b_rdy}, 0);
      check($sformatf("b2b%0d access_rsp", i), {31'b0, b_vld}, 0);
      if (i < 3) begin
        req_funct3 = b2b_f3[i+1]; req_addr = b2b_addr[i+1];
      end else req_valid = 1'b0;
      @(negedge clk);
      check($sformatf("b2b%0d rsp_valid", i), {31'b0, b_vld}, 1);
      check($sformatf("b2b%0d rsp_rdata", i), b_rd, b2b_rd[i]);
      check($sformatf("b2b%0d resp_busy", i), {31'b0, b_busy}, 0);
      check($sformatf("b2b%0d resp_ready", i), {31'b0, b_rdy}, 1);
    end
    repeat (10) @(negedge clk);
    req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h40; req_wdata = 32'h12345678; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("midwait a_busy", {31'b0, a_busy}, 1);
    reset = 1'b1;
    #1;
    check("async a_ready", {31'b0, a_rdy}, 1);
    check("async a_busy", {31'b0, a_busy}, 0);
    check("async a_rsp_valid", {31'b0, a_vld}, 0);
    check("async a_rdata", a_rd, 0);
    check("async a_err", {31'b0, a_err}, 0);
    check("async b_busy", {31'b0, b_busy}, 0);
    @(negedge clk);
    reset = 1'b0;
    stray = 0;
    repeat (6) begin
      @(negedge clk);
      if (a_vld || b_vld) stray++;
    end
    check("abandoned no_rsp", stray, 0);
    v = '{1'b0, 3'b010, 32'h40, 32'h0, 32'h0, 1'b0};
    do_req(v, 100);
    v = '{1'b0, 3'b010, 32'h440, 32'h0, 32'h0, 1'b0};
    do_req(v, 101);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
